// File: rtl/alu_arbiter_pkg.sv
// Shared ALU constants: datapath/select widths and the 74181 op-codes used by
// the arbiter and the decoder.
package alu_arbiter_pkg;

    localparam int unsigned ALU_W  = 16;
    localparam int unsigned ALU_SW = 4;

    localparam logic M_ARITH = 1'b0;
    localparam logic M_LOGIC = 1'b1;

    // M=0: A plus B;  M=1: A xor B
    localparam logic [ALU_SW-1:0] S_ADD = 4'b1001;
    localparam logic [ALU_SW-1:0] S_XOR = 4'b0110;

    // Index width for n requesters (never zero)
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between NREQ requesters and the ALU arbiter;
// requester i owns element i of every vector.
interface alu_arbiter_if
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned W    = ALU_W
);
    logic [NREQ-1:0]              req_valid;
    logic [NREQ-1:0]              req_ready;
    logic [NREQ-1:0][ALU_SW-1:0]  req_s;
    logic [NREQ-1:0]              req_m;
    logic [NREQ-1:0][W-1:0]       req_a;
    logic [NREQ-1:0][W-1:0]       req_b;
    logic [NREQ-1:0]              rsp_valid;
    logic [NREQ-1:0]              rsp_ready;
    logic [NREQ-1:0][W-1:0]       rsp_y;
    logic [NREQ-1:0]              rsp_co;

    modport master (
        output req_valid, req_s, req_m, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_y, rsp_co
    );

    modport slave (
        input  req_valid, req_s, req_m, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_y, rsp_co
    );

endinterface

// File: rtl/alu_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among req, priority starts at the
// requester after the last winner; pointer moves only when something wins.
module rr_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NREQ-1:0]                req,
    output logic [NREQ-1:0]                grant,
    output logic [idx_w(NREQ)-1:0]         grant_id
);
    localparam int unsigned IW = idx_w(NREQ);

    logic [IW-1:0] ptr;
    logic [IW-1:0] ptr_next;
    int            idx;

    // Scan from lowest to highest priority so the highest-priority hit wins last
    always_comb begin
        grant    = '0;
        grant_id = '0;
        idx      = 0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % int'(NREQ);
            if (req[IW'(idx)]) begin
                grant           = '0;
                grant[IW'(idx)] = 1'b1;
                grant_id        = IW'(idx);
            end
        end
        ptr_next = (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + IW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (|grant) begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational 74181-style ALU among NREQ requesters: round-robin
// issue into registered ALU operands, result captured one cycle later.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned W    = ALU_W
) (
    input  logic              clk,
    input  logic              rst,
    alu_arbiter_if.slave      bus,
    output logic [ALU_SW-1:0] alu_s,
    output logic              alu_m,
    output logic [W-1:0]      alu_a,
    output logic [W-1:0]      alu_b,
    input  logic [W-1:0]      alu_y,
    input  logic              alu_co
);
    localparam int unsigned IW = idx_w(NREQ);

    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] inflight;
    logic [NREQ-1:0] capture;
    logic [IW-1:0]   grant_id;
    logic [IW-1:0]   issue_id;
    logic            issue_valid;

    // A slot whose result is being consumed this cycle may be refilled: the
    // new result only lands two edges later.
    always_comb begin
        eligible = bus.req_valid & ~inflight & (~bus.rsp_valid | bus.rsp_ready);
        capture  = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            capture[i] = issue_valid && (issue_id == IW'(i));
        end
    end

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .clk      (clk),
        .rst      (rst),
        .req      (eligible),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign bus.req_ready = grant;

    // Issue stage: operands hold their last value when nothing is granted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_s       <= '0;
            alu_m       <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            issue_id    <= '0;
            issue_valid <= 1'b0;
        end else begin
            issue_valid <= |grant;
            if (|grant) begin
                alu_s    <= bus.req_s[grant_id];
                alu_m    <= bus.req_m[grant_id];
                alu_a    <= bus.req_a[grant_id];
                alu_b    <= bus.req_b[grant_id];
                issue_id <= grant_id;
            end
        end
    end

    // Per-requester response slots and outstanding flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rsp_valid <= '0;
            bus.rsp_y     <= '0;
            bus.rsp_co    <= '0;
            inflight      <= '0;
        end else begin
            for (int i = 0; i < int'(NREQ); i++) begin
                if (capture[i]) begin
                    bus.rsp_valid[i] <= 1'b1;
                    bus.rsp_y[i]     <= alu_y;
                    bus.rsp_co[i]    <= alu_co;
                end else if (bus.rsp_valid[i] && bus.rsp_ready[i]) begin
                    bus.rsp_valid[i] <= 1'b0;
                end
                if (capture[i]) begin
                    inflight[i] <= 1'b0;
                end else if (grant[i]) begin
                    inflight[i] <= 1'b1;
                end
            end
        end
    end

endmodule
